// File: rtl/wb_collector_pkg.sv
// Shared types for the writeback collector: register-file request formats and helpers.
package wb_collector_pkg;

  localparam int unsigned reg_num_w = 5;
  localparam int unsigned reg_w     = 32;

  typedef logic [reg_num_w-1:0] reg_num_t;
  typedef logic [reg_w-1:0]     reg_t;

  // Result offered by an execution unit.
  typedef struct packed {
    reg_num_t rd_num;
    reg_t     rd_value;
  } wb_req_t;

  // One register-file write port request.
  typedef struct packed {
    logic     en;
    reg_num_t rd_num;
    reg_t     rd_value;
  } rf_write_req_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_collector_rr_arbiter.sv
// Round-robin multi-grant arbiter: scans requesters from start, wrapping, and grants
// up to limit of them. Reports grants in scan order plus the last granted index.
module rr_arbiter #(
  parameter int unsigned req_cnt   = 2,
  parameter int unsigned grant_max = 1,
  localparam int unsigned idx_w    = (req_cnt > 1) ? $clog2(req_cnt) : 1,
  localparam int unsigned cnt_w    = $clog2(grant_max + 1)
) (
  input  logic [req_cnt-1:0] req,
  input  logic [idx_w-1:0]   start,
  input  logic [cnt_w-1:0]   limit,
  output logic [req_cnt-1:0] grant,
  output logic [idx_w-1:0]   order [grant_max],
  output logic [cnt_w-1:0]   grant_cnt,
  output logic [idx_w-1:0]   last
);

  // Scan from start; constant-indexed inner loops keep selects width-exact.
  always_comb begin
    int unsigned s;
    grant     = '0;
    grant_cnt = '0;
    last      = start;
    s         = 0;
    for (int unsigned g = 0; g < grant_max; g++) begin
      order[g] = '0;
    end
    for (int unsigned off = 0; off < req_cnt; off++) begin
      s = 32'(start) + off;
      if (s >= req_cnt) begin
        s = s - req_cnt;
      end
      for (int unsigned r = 0; r < req_cnt; r++) begin
        if (r == s && req[r] && grant_cnt < limit) begin
          grant[r] = 1'b1;
          for (int unsigned g = 0; g < grant_max; g++) begin
            if (g == 32'(grant_cnt)) begin
              order[g] = idx_w'(r);
            end
          end
          grant_cnt = grant_cnt + cnt_w'(1);
          last      = idx_w'(r);
        end
      end
    end
  end

endmodule

// File: rtl/wb_collector.sv
// Writeback collector: accepts results from several producers round-robin, queues them
// in acceptance order, and drains up to write_port_cnt per cycle to the register file.
module wb_collector
  import wb_collector_pkg::*;
#(
  parameter int unsigned src_cnt        = 2,
  parameter int unsigned write_port_cnt = 1,
  parameter int unsigned fifo_depth     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [src_cnt-1:0]          src_valid,
  input  wb_req_t                     src_data [src_cnt],
  output logic [src_cnt-1:0]          src_ready,
  output rf_write_req_t               write_req [write_port_cnt],
  output logic [$clog2(fifo_depth):0] occupancy
);

  localparam int unsigned ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned occ_w = $clog2(fifo_depth) + 1;
  localparam int unsigned idx_w = (src_cnt > 1) ? $clog2(src_cnt) : 1;
  localparam int unsigned cnt_w = $clog2(write_port_cnt + 1);

  wb_req_t           mem_q [fifo_depth];
  logic [ptr_w-1:0]  head_q, head_d;
  logic [ptr_w-1:0]  tail_q, tail_d;
  logic [occ_w-1:0]  occ_q, occ_d;
  logic [idx_w-1:0]  rr_q, rr_d;

  logic [cnt_w-1:0]  limit;
  logic [cnt_w-1:0]  drain_cnt;
  logic [cnt_w-1:0]  grant_cnt;
  logic [src_cnt-1:0] grant;
  logic [idx_w-1:0]  order [write_port_cnt];
  logic [idx_w-1:0]  last;

  logic [fifo_depth-1:0] wr_en;
  wb_req_t               wr_data [fifo_depth];

  // Grant budget uses free slots before this cycle's drain so ready never waits on drain.
  always_comb begin
    int unsigned free;
    free      = fifo_depth - 32'(occ_q);
    limit     = '0;
    drain_cnt = '0;
    if (en && !rst) begin
      limit     = cnt_w'(min_u(free, write_port_cnt));
      drain_cnt = cnt_w'(min_u(32'(occ_q), write_port_cnt));
    end
  end

  rr_arbiter #(
    .req_cnt   (src_cnt),
    .grant_max (write_port_cnt)
  ) u_arb (
    .req       (src_valid),
    .start     (rr_q),
    .limit     (limit),
    .grant     (grant),
    .order     (order),
    .grant_cnt (grant_cnt),
    .last      (last)
  );

  assign src_ready = grant;
  assign occupancy = occ_q;

  // Present the oldest entries on the lowest ports; idle ports are fully zeroed.
  always_comb begin
    logic [ptr_w-1:0] slot;
    slot = '0;
    for (int unsigned k = 0; k < write_port_cnt; k++) begin
      write_req[k] = '0;
      if (k < 32'(drain_cnt)) begin
        slot                  = head_q + ptr_w'(k);
        write_req[k].en       = 1'b1;
        write_req[k].rd_num   = mem_q[slot].rd_num;
        write_req[k].rd_value = mem_q[slot].rd_value;
      end
    end
  end

  // Enqueue granted results in scan order; x0 writes complete the handshake but are dropped.
  always_comb begin
    int unsigned      enq;
    logic [ptr_w-1:0] slot;
    wb_req_t          req;
    enq   = 0;
    slot  = '0;
    req   = '0;
    wr_en = '0;
    for (int unsigned i = 0; i < fifo_depth; i++) begin
      wr_data[i] = '0;
    end
    for (int unsigned g = 0; g < write_port_cnt; g++) begin
      if (g < 32'(grant_cnt)) begin
        req = src_data[order[g]];
        if (req.rd_num != '0) begin
          slot          = tail_q + ptr_w'(enq);
          wr_en[slot]   = 1'b1;
          wr_data[slot] = req;
          enq           = enq + 1;
        end
      end
    end
    tail_d = tail_q + ptr_w'(enq);
    head_d = head_q + ptr_w'(drain_cnt);
    occ_d  = occ_w'(32'(occ_q) + enq - 32'(drain_cnt));
    rr_d   = (grant_cnt != '0) ? idx_w'((32'(last) + 1) % src_cnt) : rr_q;
  end

  // Pointer, occupancy and round-robin state; reset discards queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      rr_q   <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      rr_q   <= rr_d;
    end
  end

  // FIFO storage; contents are only meaningful between head and tail, so no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < fifo_depth; i++) begin
      if (wr_en[i]) begin
        mem_q[i] <= wr_data[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_collector.sv
// Directed bench: one collector with a single write port, one with two ports and a
// two-entry FIFO so the full condition is reachable.
module tb_wb_collector;
  import wb_collector_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Single write port, depth 4.
  logic          rst, en;
  logic [1:0]    src_valid;
  wb_req_t       src_data [2];
  logic [1:0]    src_ready;
  rf_write_req_t write_req [1];
  logic [2:0]    occupancy;

  // Two write ports, depth 2.
  logic          rst2, en2;
  logic [1:0]    src_valid2;
  wb_req_t       src_data2 [2];
  logic [1:0]    src_ready2;
  rf_write_req_t write_req2 [2];
  logic [1:0]    occupancy2;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf [32];

  wb_collector #(
    .src_cnt        (2),
    .write_port_cnt (1),
    .fifo_depth     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .write_req (write_req),
    .occupancy (occupancy)
  );

  wb_collector #(
    .src_cnt        (2),
    .write_port_cnt (2),
    .fifo_depth     (2)
  ) dut2 (
    .clk       (clk),
    .rst       (rst2),
    .en        (en2),
    .src_valid (src_valid2),
    .src_data  (src_data2),
    .src_ready (src_ready2),
    .write_req (write_req2),
    .occupancy (occupancy2)
  );

  // Register file model: ascending port order, so the higher (newer) port wins.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (write_req2[k].en) rf[write_req2[k].rd_num] <= write_req2[k].rd_value;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic wb_req_t mk(input logic [4:0] rd, input logic [31:0] val);
    wb_req_t r;
    r.rd_num   = rd;
    r.rd_value = val;
    return r;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; src_valid = 2'b11;
    src_data[0] = mk(5'd1, 32'h1); src_data[1] = mk(5'd2, 32'h2);
    rst2 = 1'b1; en2 = 1'b1; src_valid2 = 2'b00;
    src_data2[0] = '0; src_data2[1] = '0;

    // Reset: nothing ready or written while rst is high.
    step(); #1;
    check("rst_ready", 64'(src_ready), 64'h0);
    check("rst_wr_en", 64'(write_req[0].en), 64'h0);
    step(); rst = 1'b0; rst2 = 1'b0; src_valid = 2'b00; #1;
    check("rst_occ", 64'(occupancy), 64'h0);
    check("rst_wr_en_after", 64'(write_req[0].en), 64'h0);
    check("rst2_occ", 64'(occupancy2), 64'h0);

    // Single transaction, latency one.
    step(); src_valid = 2'b01; src_data[0] = mk(5'd5, 32'hDEADBEEF); #1;
    check("single_ready", 64'(src_ready), 64'h1);
    step(); src_valid = 2'b00; #1;
    check("single_req", 64'(write_req[0]), {26'h0, 1'b1, 5'd5, 32'hDEADBEEF});
    check("single_occ", 64'(occupancy), 64'h1);
    step(); #1;
    check("single_en_after", 64'(write_req[0].en), 64'h0);
    check("single_occ_after", 64'(occupancy), 64'h0);

    // Restart round-robin from source 0.
    step(); rst = 1'b1;
    step(); rst = 1'b0;

    // Round-robin: grants alternate 0,1,0,1 and drain in the same order.
    for (int c = 0; c < 4; c++) begin
      step(); src_valid = 2'b11;
      src_data[0] = mk(5'd1, 32'h100 + c); src_data[1] = mk(5'd2, 32'h200 + c); #1;
      check("rr_ready", 64'(src_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
      if (c > 0) begin
        check("rr_wr_rd", 64'(write_req[0].rd_num), ((c - 1) % 2 == 0) ? 64'd1 : 64'd2);
        check("rr_wr_en", 64'(write_req[0].en), 64'h1);
      end
    end
    step(); src_valid = 2'b00; #1;
    check("rr_last", 64'(write_req[0]), {26'h0, 1'b1, 5'd2, 32'h203});

    // x0 destination: handshake completes, nothing queued or written.
    step(); src_valid = 2'b01; src_data[0] = mk(5'd0, 32'h1234); #1;
    check("x0_ready", 64'(src_ready), 64'h1);
    step(); src_valid = 2'b00; #1;
    check("x0_occ", 64'(occupancy), 64'h0);
    check("x0_en", 64'(write_req[0].en), 64'h0);

    // Stall: en low blocks accepts.
    step(); en = 1'b0; src_valid = 2'b01; src_data[0] = mk(5'd6, 32'h66); #1;
    check("stall_ready", 64'(src_ready), 64'h0);
    step(); en = 1'b1; src_valid = 2'b00; #1;
    check("stall_occ", 64'(occupancy), 64'h0);
    check("stall_en", 64'(write_req[0].en), 64'h0);

    // Two ports, depth 2: fill, observe full backpressure, then ready returns.
    step(); src_valid2 = 2'b11; src_data2[0] = mk(5'd7, 32'hA); src_data2[1] = mk(5'd8, 32'hB); #1;
    check("full_ready_a", 64'(src_ready2), 64'h3);
    check("full_occ_a", 64'(occupancy2), 64'h0);
    step(); src_data2[0] = mk(5'd3, 32'h1); src_data2[1] = mk(5'd3, 32'h2); #1;
    check("full_ready", 64'(src_ready2), 64'h0);
    check("full_occ", 64'(occupancy2), 64'h2);
    check("full_p0", 64'(write_req2[0]), {26'h0, 1'b1, 5'd7, 32'hA});
    check("full_p1", 64'(write_req2[1]), {26'h0, 1'b1, 5'd8, 32'hB});
    step(); #1;
    check("full_ready_back", 64'(src_ready2), 64'h3);
    check("full_occ_back", 64'(occupancy2), 64'h0);
    check("full_empty_en", 64'(write_req2[0].en), 64'h0);

    // Same destination on both ports: newer value on port 1 wins.
    step(); src_valid2 = 2'b00; #1;
    check("samerd_p0", 64'(write_req2[0]), {26'h0, 1'b1, 5'd3, 32'h1});
    check("samerd_p1", 64'(write_req2[1]), {26'h0, 1'b1, 5'd3, 32'h2});
    step(); src_valid2 = 2'b11; src_data2[0] = mk(5'd9, 32'h9); src_data2[1] = mk(5'd10, 32'h10); #1;
    check("samerd_x3", 64'(rf[3]), 64'h2);
    check("queue_ready", 64'(src_ready2), 64'h3);

    // Mid-operation reset discards the queued pair.
    step(); rst2 = 1'b1; #1;
    check("midrst_occ_before", 64'(occupancy2), 64'h2);
    check("midrst_en0", 64'(write_req2[0].en), 64'h0);
    check("midrst_en1", 64'(write_req2[1].en), 64'h0);
    check("midrst_ready", 64'(src_ready2), 64'h0);
    step(); rst2 = 1'b0; src_valid2 = 2'b00; #1;
    check("midrst_occ", 64'(occupancy2), 64'h0);
    check("midrst_en0_after", 64'(write_req2[0].en), 64'h0);
    check("midrst_en1_after", 64'(write_req2[1].en), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
